// File: rtl/led_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with per-digit blink and a 4-phase update handshake.
// Latency: outputs are registered, one cycle behind index/active-register changes; updates land on a frame boundary.
// Backpressure: upd_req is ignored while an update is pending or being acknowledged; the scan itself never stalls.
module led_scan_ctrl #(
  parameter logic [15:0] SCAN_DIV     = 16'd25000,
  parameter logic [5:0]  BLINK_FRAMES = 6'd32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upd_req,
  input  logic [15:0] upd_data,
  input  logic [3:0]  upd_blink,
  output logic        upd_ack,
  output logic [3:0]  digit_en,
  output logic [6:0]  seg,
  output logic        frame_tick
);

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_ACK} state_t;

  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [1:0]  idx_q, idx_d;
  logic [5:0]  blink_cnt_q, blink_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  logic [15:0] act_code_q, act_code_d;
  logic [3:0]  act_blink_q, act_blink_d;
  logic [15:0] pend_code_q, pend_code_d;
  logic [3:0]  pend_blink_q, pend_blink_d;
  logic        upd_ack_q, upd_ack_d;
  logic [3:0]  digit_en_q, digit_en_d;
  logic [6:0]  seg_q, seg_d;
  logic        frame_tick_q, frame_tick_d;

  logic        slot_tick;
  logic        frame_bnd;
  logic        blank;
  logic [3:0]  code_sel;

  // Segment patterns: a is bit 0, g is bit 6; A shows a dash, B-F are blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    case (code)
      4'h0:    seg_decode = 7'h3F;
      4'h1:    seg_decode = 7'h06;
      4'h2:    seg_decode = 7'h5B;
      4'h3:    seg_decode = 7'h4F;
      4'h4:    seg_decode = 7'h66;
      4'h5:    seg_decode = 7'h6D;
      4'h6:    seg_decode = 7'h7D;
      4'h7:    seg_decode = 7'h07;
      4'h8:    seg_decode = 7'h7F;
      4'h9:    seg_decode = 7'h6F;
      4'hA:    seg_decode = 7'h40;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  // Free-running scan timing, blink phase and registered display outputs.
  always_comb begin
    slot_tick     = (div_q == SCAN_DIV);
    frame_bnd     = slot_tick && (idx_q == 2'd3);
    div_d         = slot_tick ? 16'd0 : div_q + 16'd1;
    idx_d         = idx_q + {1'b0, slot_tick};
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_bnd) begin
      if (blink_cnt_q == BLINK_FRAMES - 6'd1) begin
        blink_cnt_d   = 6'd0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + 6'd1;
      end
    end
    code_sel     = act_code_q[{idx_q, 2'b00} +: 4];
    blank        = blink_phase_q & act_blink_q[idx_q];
    digit_en_d   = blank ? 4'b0000 : (4'b0001 << idx_q);
    seg_d        = blank ? 7'h00 : seg_decode(code_sel);
    frame_tick_d = frame_bnd;
  end

  // Update handshake: capture in IDLE, commit at the next frame boundary, hold ack until req drops.
  always_comb begin
    state_d      = state_q;
    pend_code_d  = pend_code_q;
    pend_blink_d = pend_blink_q;
    act_code_d   = act_code_q;
    act_blink_d  = act_blink_q;
    upd_ack_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (upd_req) begin
          pend_code_d  = upd_data;
          pend_blink_d = upd_blink;
          state_d      = ST_PEND;
        end
      end
      ST_PEND: begin
        if (frame_bnd) begin
          act_code_d  = pend_code_q;
          act_blink_d = pend_blink_q;
          state_d     = ST_ACK;
        end
      end
      ST_ACK: begin
        upd_ack_d = upd_req;
        if (!upd_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset blanks the display and drops any in-flight update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      div_q         <= 16'd0;
      idx_q         <= 2'd0;
      blink_cnt_q   <= 6'd0;
      blink_phase_q <= 1'b0;
      act_code_q    <= 16'd0;
      act_blink_q   <= 4'd0;
      pend_code_q   <= 16'd0;
      pend_blink_q  <= 4'd0;
      upd_ack_q     <= 1'b0;
      digit_en_q    <= 4'd0;
      seg_q         <= 7'd0;
      frame_tick_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      act_code_q    <= act_code_d;
      act_blink_q   <= act_blink_d;
      pend_code_q   <= pend_code_d;
      pend_blink_q  <= pend_blink_d;
      upd_ack_q     <= upd_ack_d;
      digit_en_q    <= digit_en_d;
      seg_q         <= seg_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign upd_ack    = upd_ack_q;
  assign digit_en   = digit_en_q;
  assign seg        = seg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl with a 3-cycle slot and 2-frame blink half-period.
// Reference outputs come from edge-count arithmetic plus a protocol-level update model.
// Directed scenarios add hand-computed literal expectations.
module tb_led_scan_ctrl;
  localparam int D     = 2;
  localparam int BF    = 2;
  localparam int SLOT  = D + 1;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        upd_req = 1'b0;
  logic [15:0] upd_data = 16'h0;
  logic [3:0]  upd_blink = 4'h0;
  logic        upd_ack;
  logic [3:0]  digit_en;
  logic [6:0]  seg;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  led_scan_ctrl #(.SCAN_DIV(16'd2), .BLINK_FRAMES(6'd2)) dut (
    .clk(clk), .reset(reset), .upd_req(upd_req), .upd_data(upd_data),
    .upd_blink(upd_blink), .upd_ack(upd_ack), .digit_en(digit_en),
    .seg(seg), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] c);
    case (c)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  // Model: n = index of the next clock edge counted from reset release.
  int          n = 0;
  int          mode = 0;
  logic [15:0] m_code = 16'h0, m_pend_code = 16'h0;
  logic [3:0]  m_blink = 4'h0, m_pend_blink = 4'h0;
  logic        m_valid = 1'b0;
  logic [3:0]  exp_digit = 4'h0;
  logic [6:0]  exp_seg = 7'h0;
  logic        exp_ack = 1'b0, exp_ft = 1'b0;

  always @(posedge clk) begin
    int idx;
    bit bnd, phase, blank;
    if (reset) begin
      n = 0; mode = 0; m_code = 16'h0; m_blink = 4'h0;
      exp_digit = 4'h0; exp_seg = 7'h0; exp_ack = 1'b0; exp_ft = 1'b0;
      m_valid = 1'b1;
    end else begin
      idx   = (n / SLOT) % 4;
      bnd   = (n % FRAME) == FRAME - 1;
      phase = (((n / FRAME) / BF) % 2) == 1;
      blank = phase && m_blink[idx];
      exp_digit = blank ? 4'h0 : 4'(4'b0001 << idx);
      exp_seg   = blank ? 7'h00 : seg_of(m_code[idx*4 +: 4]);
      exp_ft    = bnd;
      exp_ack   = (mode == 2) && upd_req;
      case (mode)
        0: if (upd_req) begin m_pend_code = upd_data; m_pend_blink = upd_blink; mode = 1; end
        1: if (bnd) begin m_code = m_pend_code; m_blink = m_pend_blink; mode = 2; end
        default: if (!upd_req) mode = 0;
      endcase
      n++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_digit_en", digit_en, exp_digit);
      check("model_seg", seg, exp_seg);
      check("model_upd_ack", upd_ack, exp_ack);
      check("model_frame_tick", frame_tick, exp_ft);
    end
  end

  task automatic wait_ack(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (upd_ack) break;
      @(negedge clk);
    end
    if (!upd_ack) check("ack_timeout", upd_ack, 1);
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < FRAME; i++) begin
      if (n % FRAME == ph) break;
      @(negedge clk);
    end
  endtask

  // Samples one full frame, checking one-hot select and the literal pattern per digit.
  task automatic check_frame(input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] e;
    for (int i = 0; i < FRAME; i++) begin
      case (digit_en)
        4'b0001: e = e0;
        4'b0010: e = e1;
        4'b0100: e = e2;
        default: e = e3;
      endcase
      check("frame_onehot", 32'($onehot(digit_en)), 1);
      check("frame_seg", seg, e);
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt, cnt2, n0;
    repeat (3) @(negedge clk);
    check("rst_digit_en", digit_en, 4'h0);
    check("rst_seg", seg, 7'h00);
    check("rst_ack", upd_ack, 0);
    check("rst_frame_tick", frame_tick, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_digit_en", digit_en, 4'b0001);
    check("rel_seg", seg, 7'h3F);
    cnt = 0;
    repeat (24) begin @(negedge clk); if (frame_tick) cnt++; end
    check("frame_tick_count", cnt, 2);

    // Mid-frame update: nothing changes before the boundary.
    wait_phase(5);
    upd_data = 16'h9A31; upd_blink = 4'h0; upd_req = 1'b1;
    @(negedge clk);
    check("no_change_yet", seg, 7'h3F);
    wait_ack(40);
    check_frame(7'h06, 7'h4F, 7'h40, 7'h6F);
    upd_req = 1'b0;
    @(negedge clk);
    check("ack_fall", upd_ack, 0);

    // Blink digit1: over 4 frames it is dark for exactly 2 slots.
    upd_data = 16'h1234; upd_blink = 4'b0010; upd_req = 1'b1;
    wait_ack(40);
    upd_req = 1'b0;
    @(negedge clk);
    cnt = 0; cnt2 = 0;
    repeat (4 * FRAME) begin
      @(negedge clk);
      if (digit_en == 4'h0) cnt++;
      if (digit_en == 4'h0 && seg == 7'h00) cnt2++;
    end
    check("blink_dark_cycles", cnt, 2 * SLOT);
    check("blink_blank_cycles", cnt2, 2 * SLOT);

    // Request in the boundary cycle applies one frame later; PEND ignores new data.
    wait_phase(FRAME - 1);
    upd_data = 16'h5678; upd_blink = 4'h0; upd_req = 1'b1;
    n0 = n;
    @(negedge clk);
    upd_data = 16'hFFFF; upd_blink = 4'hF;
    wait_ack(40);
    check("late_apply_cycles", n - n0, FRAME + 2);
    check_frame(7'h7F, 7'h07, 7'h7D, 7'h6D);
    upd_req = 1'b0;
    @(negedge clk);

    // Reset while pending: no ack, display back to zeros.
    wait_phase(2);
    upd_data = 16'h1111; upd_blink = 4'h0; upd_req = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1; upd_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pend_ack", upd_ack, 0);
    reset = 1'b0;
    cnt = 0;
    repeat (2 * FRAME) begin @(negedge clk); if (upd_ack) cnt++; end
    check("no_ack_after_rst", cnt, 0);
    check_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F);

    // Follow-up handshake with code C on digit1.
    upd_data = 16'h00C0; upd_req = 1'b1;
    wait_ack(40);
    check_frame(7'h3F, 7'h00, 7'h3F, 7'h3F);
    upd_req = 1'b0;
    @(negedge clk);
    check("final_ack_fall", upd_ack, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end
endmodule
